risc16_mem: RTL and testbench
=============================

# risc16_mem

Unified instruction/data memory responder for the `risc16f` pipeline. It answers the core's instruction-fetch port (`iaddr`/`ioe`/`idin`) and data port (`daddr`/`doe`/`dwe`/`ddout`/`ddin`) with same-cycle combinational reads and clocked writes. A valid/ready loader port lets a host stream a program image into memory. The block holds the core in reset while a load runs, so the core restarts from PC 0 on completion.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits, giving 2^ADDR_WIDTH 16-bit words.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `iaddr` in 16: core instruction byte address; bits [ADDR_WIDTH:1] select the word, bit 0 is ignored.
- `ioe` in 1: instruction read enable.
- `idin` out 16: instruction word to the core.
- `daddr` in 16: core data byte address; same decode as `iaddr`.
- `doe` in 1: data read enable.
- `dwe` in 1: data write enable.
- `ddout` in 16: write data from the core.
- `ddin` out 16: read data to the core.
- `cpu_rst` out 1: reset to the core; connect it to the core's `rst`.
- `ld_start` in 1: single-cycle request to begin a load.
- `ld_base` in 16: load start byte address; bit 0 is ignored. Sampled with `ld_start`.
- `ld_len` in 16: number of words to load. Sampled with `ld_start`.
- `ld_data` in 16: load word.
- `ld_valid` in 1: `ld_data` is valid.
- `ld_ready` out 1: the block accepts `ld_data`.
- `ld_busy` out 1: a load or flush is in progress.
- `ld_done` out 1: one-cycle completion pulse.

## Operation
- Storage is an array of 2^ADDR_WIDTH × 16. `rst` does not clear it; contents survive reset.
- Address decode: word index = addr[ADDR_WIDTH:1]. Upper bits are ignored, so addresses alias and wrap.
- State machine has three states: RUN (reset state), LOAD, FLUSH.
- RUN:
  - `idin` = ioe ? mem[iaddr] : 16'h0000.
  - `ddin` = doe ? mem[daddr] : 16'h0000.
  - If `dwe`=1, mem[daddr] <= ddout at the clock edge.
- RUN → LOAD: `ld_start`=1 and `ld_len`≠0. On entry, latch ptr = ld_base[ADDR_WIDTH:1] and cnt = ld_len.
- RUN → FLUSH: `ld_start`=1 and `ld_len`=0. No memory is written.
- LOAD:
  - `ld_ready`=1.
  - On each `ld_valid`&&`ld_ready`: mem[ptr] <= ld_data, ptr <= ptr+1 (mod 2^ADDR_WIDTH), cnt <= cnt-1.
  - The handshake that brings cnt to 0 moves the state to FLUSH.
  - `ld_valid` may drop for any number of cycles; the state holds.
- FLUSH: lasts exactly one cycle, then RUN. `ld_done`=1 during this cycle only.
- Outside RUN:
  - Core-port writes are ignored.
  - `idin` and `ddin` read 16'h0000, which is a NOP to the core.
  - `ld_start` is ignored.
- `cpu_rst` = rst | (state≠RUN), combinational. `ld_busy` = (state≠RUN).
- `rst` in any state: next state RUN, cnt and ptr cleared, the load is aborted. Words already written stay in memory. No `ld_done` pulse is issued.
- `dwe` and `doe` together at the same address: `ddin` returns the old contents that cycle. The new value is visible from the next cycle.
- `dwe` at the same word as `iaddr`: `idin` returns the old word this cycle and the new word next cycle.

## Timing
- Reset values: state RUN, `cpu_rst`=1 while `rst`=1 (0 after release), `ld_ready`=0, `ld_busy`=0, `ld_done`=0. `idin` and `ddin` follow the combinational rules above.
- Read latency is 0 cycles, combinational from address and enable. This matches the core sampling `idin` and `ddin` at the end of the same cycle.
- Write latency: the value written at edge N is readable in cycle N+1.
- Load of L words with `ld_valid` held high: LOAD lasts L cycles, FLUSH 1 cycle. `cpu_rst` is high for L+1 cycles after the `ld_start` cycle. The core fetches from PC 0 in the first RUN cycle after the `cpu_rst` release edge.
- `ld_ready` depends only on state, never on `ld_valid`; there is no combinational path from valid to ready.

## Test plan
- Reset retention:
  - Stimulus: in RUN, dwe with daddr=0x0010, ddout=0xBEEF; assert `rst` for 2 cycles; then doe with daddr=0x0010 (and 0x0011).
  - Required: `ddin`=0xBEEF for both addresses.
- Basic load:
  - Stimulus: ld_start with ld_base=0x0000, ld_len=3; stream 0x2101, 0x2202, 0x0000 with `ld_valid` held high.
  - Required: `ld_ready` high for 3 cycles; `ld_done` high for 1 cycle; `cpu_rst` high for 4 cycles; then iaddr=0x0002 gives `idin`=0x2202.
- Valid gaps and wrap, ADDR_WIDTH=10:
  - Stimulus: ld_base=0x07FE, ld_len=2, with one idle cycle between the two beats; data 0xAAAA then 0x5555.
  - Required: mem[1023]=0xAAAA, mem[0]=0x5555; LOAD lasts 3 cycles.
- Zero-length load:
  - Stimulus: ld_start with ld_len=0.
  - Required: exactly one FLUSH cycle with `ld_done`=1 and `cpu_rst`=1; memory unchanged.
- Abort:
  - Stimulus: `rst` asserted after 2 of 5 load beats.
  - Required: state RUN, `ld_busy`=0, no `ld_done` pulse; the first 2 words are present and the rest are unchanged.
- Core-port conflicts:
  - Stimulus: dwe and doe at 0x0020 in the same cycle with ddout=0x1234 over old contents 0x0F0F; separately, core `dwe` asserted during LOAD.
  - Required: `ddin`=0x0F0F that cycle and 0x1234 the next; the `dwe` during LOAD causes no write.

Source files
------------

// File: rtl/risc16_mem.sv
// Unified instruction/data memory for the risc16f core. Core reads are combinational
// and writes are clocked. A valid/ready loader streams a program image in while the core is held in reset.
module risc16_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iaddr,
    input  logic        ioe,
    output logic [15:0] idin,
    input  logic [15:0] daddr,
    input  logic        doe,
    input  logic        dwe,
    input  logic [15:0] ddout,
    output logic [15:0] ddin,
    output logic        cpu_rst,
    input  logic        ld_start,
    input  logic [15:0] ld_base,
    input  logic [15:0] ld_len,
    input  logic [15:0] ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        ld_done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Handshake: a load word transfers on a rising clk edge where ld_valid && ld_ready.
    // ld_ready is a registered decode of the state and never looks at ld_valid.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ld_ready_q, ld_ready_d;
    logic                  ld_busy_q, ld_busy_d;
    logic                  ld_done_q, ld_done_d;

    logic [15:0]           mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [15:0]           mem_wdata;
    logic [ADDR_WIDTH-1:0] iidx, didx;
    logic                  in_run;
    logic                  unused_addr_bits;

    assign iidx   = iaddr[ADDR_WIDTH:1];
    assign didx   = daddr[ADDR_WIDTH:1];
    assign in_run = (state_q == ST_RUN);

    // Byte-lane bit 0 and the aliased upper address bits are intentionally dropped.
    assign unused_addr_bits = ^{iaddr, daddr, ld_base};

    // Outside RUN the core sees 16'h0000, which it executes as a NOP.
    assign idin = (in_run && ioe) ? mem[iidx] : 16'h0000;
    assign ddin = (in_run && doe) ? mem[didx] : 16'h0000;

    assign cpu_rst  = rst | ld_busy_q;
    assign ld_ready = ld_ready_q;
    assign ld_busy  = ld_busy_q;
    assign ld_done  = ld_done_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = didx;
        mem_wdata = ddout;
        case (state_q)
            ST_RUN: begin
                mem_we = dwe;
                if (ld_start) begin
                    if (ld_len != 16'd0) begin
                        state_d = ST_LOAD;
                        ptr_d   = ld_base[ADDR_WIDTH:1];
                        cnt_d   = ld_len;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = ld_data;
                    ptr_d     = ptr_q + 1'b1;
                    cnt_d     = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        // Reset aborts a load mid-stream; words already written are kept.
        if (rst) begin
            state_d = ST_RUN;
            ptr_d   = '0;
            cnt_d   = 16'd0;
            mem_we  = 1'b0;
        end
        ld_ready_d = (state_d == ST_LOAD);
        ld_busy_d  = (state_d != ST_RUN);
        ld_done_d  = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            ptr_q      <= '0;
            cnt_q      <= 16'd0;
            ld_ready_q <= 1'b0;
            ld_busy_q  <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ld_ready_q <= ld_ready_d;
            ld_busy_q  <= ld_busy_d;
            ld_done_q  <= ld_done_d;
        end
    end

    // Storage has no reset so a program image survives a core reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_risc16_mem.sv
// Self-checking bench for risc16_mem: reset retention, loads with gaps/wrap,
// zero-length load, abort by reset and core-port write/read conflicts.
module tb_risc16_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] iaddr, daddr, ddout, ld_base, ld_len, ld_data;
    logic        ioe, doe, dwe, ld_start, ld_valid;
    logic [15:0] idin, ddin;
    logic        cpu_rst, ld_ready, ld_busy, ld_done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] load_data[16];

    risc16_mem #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .iaddr(iaddr), .ioe(ioe), .idin(idin),
        .daddr(daddr), .doe(doe), .dwe(dwe), .ddout(ddout), .ddin(ddin),
        .cpu_rst(cpu_rst),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .ld_done(ld_done)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iaddr = 16'h0; ioe = 1'b0; daddr = 16'h0; doe = 1'b0; dwe = 1'b0;
        ddout = 16'h0; ld_start = 1'b0; ld_base = 16'h0; ld_len = 16'h0;
        ld_data = 16'h0; ld_valid = 1'b0;
    endtask

    task automatic write_d(input logic [15:0] addr, input logic [15:0] data);
        dwe = 1'b1; daddr = addr; ddout = data;
        next_cycle();
        dwe = 1'b0;
    endtask

    task automatic read_d(input logic [15:0] addr, output logic [15:0] got);
        doe = 1'b1; daddr = addr;
        @(negedge clk);
        got = ddin;
        next_cycle();
        doe = 1'b0;
    endtask

    // Streams load_data[0..len-1]; gap_after inserts one idle cycle before that beat,
    // abort_after asserts rst for one cycle once that many beats have transferred.
    task automatic run_load(input logic [15:0] base, input int len, input int gap_after,
                            input int abort_after, output int rdy_cyc, output int done_cyc,
                            output int crst_cyc, output bit timed_out);
        int  idx;
        bit  gapped, aborted;
        next_cycle();
        ld_start = 1'b1; ld_base = base; ld_len = 16'(len); ld_valid = 1'b0;
        next_cycle();
        ld_start = 1'b0;
        idx = 0; gapped = 0; aborted = 0;
        rdy_cyc = 0; done_cyc = 0; crst_cyc = 0; timed_out = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (abort_after >= 0 && idx == abort_after && !aborted) begin
                rst = 1'b1; aborted = 1;
                ld_valid = 1'b1; ld_data = load_data[idx];
            end else begin
                rst = 1'b0;
                if (idx < len && !(idx == gap_after && !gapped)) begin
                    ld_valid = 1'b1; ld_data = load_data[idx];
                end else begin
                    ld_valid = 1'b0;
                    if (idx == gap_after) gapped = 1;
                end
            end
            @(negedge clk);
            if (ld_ready) rdy_cyc++;
            if (ld_done) done_cyc++;
            if (cpu_rst) crst_cyc++;
            if (ld_ready && ld_valid && !rst) idx++;
            if (c > 0 && !ld_busy && !cpu_rst) begin
                timed_out = 1'b0;
                break;
            end
            next_cycle();
        end
        next_cycle();
        rst = 1'b0; ld_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({cpu_rst, ld_ready, ld_busy, ld_done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs: got cpu_rst/ready/busy/done=%b required 1000",
                     {cpu_rst, ld_ready, ld_busy, ld_done});
        end
        checks++;
        if (idin !== 16'h0000 || ddin !== 16'h0000) begin
            errors++;
            $display("FAIL reset_disabled_reads: got idin=%h ddin=%h required 0000", idin, ddin);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got cpu_rst=%b required 0", cpu_rst);
        end
        next_cycle();
    endtask

    task automatic test_reset_retention();
        logic [15:0] got;
        write_d(16'h0010, 16'hBEEF);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hBEEF);
        for (int i = 0; i < 2; i++) begin
            read_d(16'h0010 + 16'(i), got);
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL retention_%0d: got %h required %h", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_basic_load();
        int rc, dc, cc;
        bit to;
        load_data[0] = 16'h2101; load_data[1] = 16'h2202; load_data[2] = 16'h0000;
        ioe = 1'b1; iaddr = 16'h0000;
        run_load(16'h0000, 3, -1, -1, rc, dc, cc, to);
        checks++;
        if (to || rc != 3 || dc != 1 || cc != 4) begin
            errors++;
            $display("FAIL basic_load_timing: got timeout=%0d ready=%0d done=%0d cpu_rst=%0d required 0/3/1/4",
                     to, rc, dc, cc);
        end
        exp_q.push_back(16'h2202);
        exp_q.push_back(16'h2202);
        exp_q.push_back(16'h2101);
        for (int i = 0; i < 3; i++) begin
            iaddr = (i == 0) ? 16'h0002 : (i == 1) ? 16'h0003 : 16'h0000;
            @(negedge clk);
            checks++;
            if (idin !== exp_q[0]) begin
                errors++;
                $display("FAIL basic_load_fetch_%0d: got %h required %h", i, idin, exp_q[0]);
            end
            void'(exp_q.pop_front());
            next_cycle();
        end
        ioe = 1'b0;
    endtask

    task automatic test_gap_wrap();
        int rc, dc, cc;
        bit to;
        logic [15:0] got;
        load_data[0] = 16'hAAAA; load_data[1] = 16'h5555;
        run_load(16'h07FE, 2, 1, -1, rc, dc, cc, to);
        checks++;
        if (to || rc != 3 || dc != 1 || cc != 4) begin
            errors++;
            $display("FAIL gap_wrap_timing: got timeout=%0d ready=%0d done=%0d cpu_rst=%0d required 0/3/1/4",
                     to, rc, dc, cc);
        end
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'h5555);
        exp_q.push_back(16'h5555);
        for (int i = 0; i < 3; i++) begin
            read_d((i == 0) ? 16'h07FE : (i == 1) ? 16'h0000 : 16'h0800, got);
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL gap_wrap_word_%0d: got %h required %h", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_zero_len();
        int rc, dc, cc;
        bit to;
        logic [15:0] got;
        load_data[0] = 16'hFFFF;
        run_load(16'h0000, 0, -1, -1, rc, dc, cc, to);
        checks++;
        if (to || rc != 0 || dc != 1 || cc != 1) begin
            errors++;
            $display("FAIL zero_len_timing: got timeout=%0d ready=%0d done=%0d cpu_rst=%0d required 0/0/1/1",
                     to, rc, dc, cc);
        end
        exp_q.push_back(16'h5555);
        exp_q.push_back(16'h2202);
        for (int i = 0; i < 2; i++) begin
            read_d(16'(2 * i), got);
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL zero_len_unchanged_%0d: got %h required %h", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_abort();
        int rc, dc, cc;
        bit to;
        logic [15:0] got;
        for (int i = 0; i < 5; i++) write_d(16'h0100 + 16'(2 * i), 16'hC000 + 16'(i));
        for (int i = 0; i < 5; i++) load_data[i] = 16'h7000 + 16'(i);
        run_load(16'h0100, 5, -1, 2, rc, dc, cc, to);
        checks++;
        if (to || dc != 0) begin
            errors++;
            $display("FAIL abort_no_done: got timeout=%0d done=%0d required 0/0", to, dc);
        end
        @(negedge clk);
        checks++;
        if ({ld_busy, ld_ready, cpu_rst} !== 3'b000) begin
            errors++;
            $display("FAIL abort_state_run: got busy/ready/cpu_rst=%b required 000",
                     {ld_busy, ld_ready, cpu_rst});
        end
        next_cycle();
        for (int i = 0; i < 5; i++) exp_q.push_back((i < 2) ? 16'h7000 + 16'(i) : 16'hC000 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            read_d(16'h0100 + 16'(2 * i), got);
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL abort_word_%0d: got %h required %h", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_conflicts();
        logic [15:0] got;
        write_d(16'h0020, 16'h0F0F);
        dwe = 1'b1; doe = 1'b1; ioe = 1'b1;
        daddr = 16'h0020; iaddr = 16'h0020; ddout = 16'h1234;
        exp_q.push_back(16'h0F0F);
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ddin !== exp_q[0] || idin !== exp_q[0]) begin
                errors++;
                $display("FAIL conflict_cycle_%0d: got ddin=%h idin=%h required %h",
                         i, ddin, idin, exp_q[0]);
            end
            void'(exp_q.pop_front());
            next_cycle();
            dwe = 1'b0;
        end
        ioe = 1'b0;
        // Core write attempted across LOAD and FLUSH must be dropped.
        ld_start = 1'b1; ld_base = 16'h0200; ld_len = 16'd2;
        next_cycle();
        ld_start = 1'b0;
        dwe = 1'b1; doe = 1'b1; daddr = 16'h0020; ddout = 16'hDEAD;
        ld_valid = 1'b1; ld_data = 16'h3333;
        @(negedge clk);
        checks++;
        if (ld_busy !== 1'b1 || ddin !== 16'h0000) begin
            errors++;
            $display("FAIL load_core_blocked: got busy=%b ddin=%h required 1/0000", ld_busy, ddin);
        end
        next_cycle();
        ld_data = 16'h4444;
        next_cycle();
        ld_valid = 1'b0;
        next_cycle();
        dwe = 1'b0; doe = 1'b0;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        for (int i = 0; i < 3; i++) begin
            read_d((i == 0) ? 16'h0020 : (i == 1) ? 16'h0200 : 16'h0202, got);
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL load_dwe_ignored_%0d: got %h required %h", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_random_rw();
        logic [15:0] got;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 16'h0300 + 16'(2 * $urandom_range(0, 63));
            exp_q.push_back(16'($urandom_range(0, 65535)));
            write_d(a, exp_q[0]);
            read_d(a, got);
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL random_rw_%0d: addr %h got %h required %h", i, a, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_reset_retention();
        test_basic_load();
        test_gap_wrap();
        test_zero_len();
        test_abort();
        test_conflicts();
        test_random_rw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
